// File: rtl/panel_pkg.sv
// Shared constants and types for the front-panel input block.
// Key codes 0-9 are digits; codes 14 and 15 are ignored.
package panel_pkg;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
  localparam logic [3:0] KEY_POWER     = 4'd10;
  localparam logic [3:0] KEY_CLEAR     = 4'd11;
  localparam logic [3:0] KEY_START     = 4'd12;
  localparam logic [3:0] KEY_CANCEL    = 4'd13;

  localparam logic [6:0] MAX_TIME   = 7'd120;
  localparam logic [1:0] MAX_DIGITS = 2'd3;

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } key_state_t;

endpackage

// File: rtl/panel_entry_level_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer.
// The stable output moves only after DEBOUNCE_CYCLES samples that all differ from it.
module level_debounce #(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] stable
);

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] meta;
  logic [7:0]       cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= '0;
      sync   <= '0;
      stable <= '0;
      cnt    <= 8'd0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (sync != stable) begin
        if (cnt == DB_LAST) begin
          stable <= sync;
          cnt    <= 8'd0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        cnt <= 8'd0;
      end
    end
  end

endmodule

// File: rtl/panel_entry.sv
// Front-panel input block: debounced keypad actions, timer entry, power toggle and door level.
// state      | meaning
// RELEASED   | no key down, waiting for a press
// PRESS_DB   | key down, counting stable samples of one code
// HELD       | action done, waiting for release
// RELEASE_DB | key up, counting stable release samples
module panel_entry
  import panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_press,
  input  logic [3:0] key_code,
  input  logic       door_raw,
  output logic [6:0] timer,
  output logic       power,
  output logic       door_status,
  output logic       start_button,
  output logic       cancel_button,
  output logic       entry_error
);

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam bit         DB_ONE  = (DEBOUNCE_CYCLES == 1);

  logic [4:0]  key_sync;
  logic [4:0]  key_stable_unused;
  logic        door_sync_unused;
  logic        press_s;
  logic [3:0]  code_s;

  key_state_t  state;
  logic [3:0]  cap_code;
  logic [7:0]  cnt;
  logic [1:0]  digit_cnt;

  logic        fire;
  logic [3:0]  fire_code;
  logic [6:0]  base;
  logic [10:0] nxt;
  logic        digit_ok;

  // Only the synchronizer of this instance matters; the key FSM does its own debounce.
  level_debounce #(.WIDTH(5), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    ({key_code, key_press}),
    .sync   (key_sync),
    .stable (key_stable_unused)
  );

  level_debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_door (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (door_raw),
    .sync   (door_sync_unused),
    .stable (door_status)
  );

  assign press_s = key_sync[0];
  assign code_s  = key_sync[4:1];

  always_comb begin
    fire      = 1'b0;
    fire_code = code_s;
    case (state)
      RELEASED: fire = press_s && DB_ONE;
      PRESS_DB: fire = press_s && ((code_s != cap_code) ? DB_ONE : (cnt == DB_LAST));
      default:  fire = 1'b0;
    endcase
    // A fresh entry (after reset, START, CLEAR or CANCEL) replaces the timer.
    base     = (digit_cnt == 2'd0) ? 7'd0 : timer;
    nxt      = 11'(base) * 11'd10 + 11'(fire_code);
    digit_ok = (digit_cnt < MAX_DIGITS) && (nxt <= 11'(MAX_TIME));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RELEASED;
      cap_code      <= 4'd0;
      cnt           <= 8'd0;
      digit_cnt     <= 2'd0;
      timer         <= 7'd0;
      power         <= 1'b0;
      start_button  <= 1'b0;
      cancel_button <= 1'b0;
      entry_error   <= 1'b0;
    end else begin
      start_button  <= 1'b0;
      cancel_button <= 1'b0;
      entry_error   <= 1'b0;

      case (state)
        RELEASED: begin
          if (press_s) begin
            cap_code <= code_s;
            cnt      <= fire ? 8'd0 : 8'd1;
            state    <= fire ? HELD : PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (!press_s) begin
            state <= RELEASED;
            cnt   <= 8'd0;
          end else if (fire) begin
            state <= HELD;
            cnt   <= 8'd0;
          end else if (code_s != cap_code) begin
            cap_code <= code_s;
            cnt      <= 8'd1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HELD: begin
          if (!press_s) begin
            state <= DB_ONE ? RELEASED : RELEASE_DB;
            cnt   <= DB_ONE ? 8'd0 : 8'd1;
          end
        end
        RELEASE_DB: begin
          if (press_s) begin
            state <= HELD;
            cnt   <= 8'd0;
          end else if (cnt == DB_LAST) begin
            state <= RELEASED;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= 8'd0;
        end
      endcase

      if (fire) begin
        case (fire_code)
          KEY_POWER: power <= ~power;
          KEY_CLEAR: begin
            timer     <= 7'd0;
            digit_cnt <= 2'd0;
          end
          KEY_START: begin
            start_button <= 1'b1;
            digit_cnt    <= 2'd0;
          end
          KEY_CANCEL: begin
            cancel_button <= 1'b1;
            timer         <= 7'd0;
            digit_cnt     <= 2'd0;
          end
          default: begin
            if (fire_code <= KEY_DIGIT_MAX) begin
              if (digit_ok) begin
                timer     <= nxt[6:0];
                digit_cnt <= digit_cnt + 2'd1;
              end else begin
                entry_error <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_panel_entry.sv
// Directed bench for panel_entry with DEBOUNCE_CYCLES=4 and hand-computed expectations.
module tb_panel_entry;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_press;
  logic [3:0] key_code;
  logic       door_raw;
  logic [6:0] timer;
  logic       power;
  logic       door_status;
  logic       start_button;
  logic       cancel_button;
  logic       entry_error;

  int total = 0;
  int bad   = 0;
  int n_start  = 0;
  int n_cancel = 0;
  int n_error  = 0;

  panel_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_press     (key_press),
    .key_code      (key_code),
    .door_raw      (door_raw),
    .timer         (timer),
    .power         (power),
    .door_status   (door_status),
    .start_button  (start_button),
    .cancel_button (cancel_button),
    .entry_error   (entry_error)
  );

  always #5 clk = ~clk;

  // Each pulse spans one posedge-to-posedge window, so exactly one falling edge sees it.
  always @(negedge clk) begin
    if (rst_n) begin
      n_start  += int'(start_button);
      n_cancel += int'(cancel_button);
      n_error  += int'(entry_error);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic press_key(input logic [3:0] c);
    @(negedge clk);
    key_code  = c;
    key_press = 1'b1;
    repeat (8) @(negedge clk);
    key_press = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; key_press = 1'b0; key_code = 4'd0; door_raw = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (timer !== 7'd0) begin bad++; $display("FAIL reset_timer got=%0d want=0", timer); end
    total++; if ({power, door_status, start_button, cancel_button, entry_error} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=00000",
                      {power, door_status, start_button, cancel_button, entry_error});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_digit;
    int s0, c0, e0;
    s0 = n_start; c0 = n_cancel; e0 = n_error;
    @(negedge clk);
    key_code = 4'd9; key_press = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++; if (timer !== 7'd0) begin bad++; $display("FAIL latency_early got=%0d want=0", timer); end
    @(posedge clk);
    #1;
    total++; if (timer !== 7'd9) begin bad++; $display("FAIL latency_edge6 got=%0d want=9", timer); end
    @(negedge clk);
    key_press = 1'b0;
    repeat (8) @(negedge clk);
    total++; if ((n_start - s0) + (n_cancel - c0) + (n_error - e0) !== 0) begin
      bad++; $display("FAIL digit9_pulses got=%0d want=0", (n_start - s0) + (n_cancel - c0) + (n_error - e0));
    end
  endtask

  task automatic test_entry_start;
    int s0;
    press_key(4'd11);
    total++; if (timer !== 7'd0) begin bad++; $display("FAIL clear got=%0d want=0", timer); end
    press_key(4'd1);
    press_key(4'd2);
    total++; if (timer !== 7'd12) begin bad++; $display("FAIL entry_12 got=%0d want=12", timer); end
    press_key(4'd0);
    total++; if (timer !== 7'd120) begin bad++; $display("FAIL entry_120 got=%0d want=120", timer); end
    s0 = n_start;
    press_key(4'd12);
    total++; if (n_start - s0 !== 1) begin bad++; $display("FAIL start_pulses got=%0d want=1", n_start - s0); end
    total++; if (timer !== 7'd120) begin bad++; $display("FAIL start_keeps got=%0d want=120", timer); end
    press_key(4'd5);
    total++; if (timer !== 7'd5) begin bad++; $display("FAIL fresh_entry got=%0d want=5", timer); end
  endtask

  task automatic test_overflow;
    int e0;
    press_key(4'd11);
    press_key(4'd1);
    press_key(4'd2);
    e0 = n_error;
    press_key(4'd1);
    total++; if (n_error - e0 !== 1) begin bad++; $display("FAIL over_max_err got=%0d want=1", n_error - e0); end
    total++; if (timer !== 7'd12) begin bad++; $display("FAIL over_max_timer got=%0d want=12", timer); end
    press_key(4'd11);
    press_key(4'd1);
    press_key(4'd0);
    press_key(4'd0);
    total++; if (timer !== 7'd100) begin bad++; $display("FAIL entry_100 got=%0d want=100", timer); end
    e0 = n_error;
    press_key(4'd1);
    total++; if (n_error - e0 !== 1) begin bad++; $display("FAIL fourth_digit_err got=%0d want=1", n_error - e0); end
    total++; if (timer !== 7'd100) begin bad++; $display("FAIL fourth_digit_timer got=%0d want=100", timer); end
  endtask

  task automatic test_glitch_switch;
    int e0;
    press_key(4'd11);
    e0 = n_error;
    @(negedge clk); key_code = 4'd3; key_press = 1'b1;
    @(negedge clk); key_press = 1'b1;
    @(negedge clk); key_press = 1'b0;
    @(negedge clk); key_press = 1'b1;
    @(negedge clk);
    @(negedge clk); key_code = 4'd7;
    repeat (5) @(posedge clk);
    #1;
    total++; if (timer !== 7'd0) begin bad++; $display("FAIL switch_early got=%0d want=0", timer); end
    @(posedge clk);
    #1;
    total++; if (timer !== 7'd7) begin bad++; $display("FAIL switch_apply got=%0d want=7", timer); end
    repeat (10) @(negedge clk);
    key_press = 1'b0;
    repeat (8) @(negedge clk);
    total++; if (timer !== 7'd7) begin bad++; $display("FAIL one_action got=%0d want=7", timer); end
    total++; if (n_error - e0 !== 0) begin bad++; $display("FAIL glitch_err got=%0d want=0", n_error - e0); end
  endtask

  task automatic test_power_cancel;
    int c0;
    press_key(4'd10);
    total++; if (power !== 1'b1) begin bad++; $display("FAIL power_on got=%b want=1", power); end
    press_key(4'd10);
    total++; if (power !== 1'b0) begin bad++; $display("FAIL power_off got=%b want=0", power); end
    press_key(4'd11);
    press_key(4'd4);
    press_key(4'd5);
    total++; if (timer !== 7'd45) begin bad++; $display("FAIL entry_45 got=%0d want=45", timer); end
    c0 = n_cancel;
    @(negedge clk); key_code = 4'd13; key_press = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++; if ({cancel_button, timer} !== {1'b0, 7'd45}) begin
      bad++; $display("FAIL cancel_early got=%b/%0d want=0/45", cancel_button, timer);
    end
    @(posedge clk);
    #1;
    total++; if ({cancel_button, timer} !== {1'b1, 7'd0}) begin
      bad++; $display("FAIL cancel_edge got=%b/%0d want=1/0", cancel_button, timer);
    end
    @(posedge clk);
    #1;
    total++; if (cancel_button !== 1'b0) begin bad++; $display("FAIL cancel_width got=%b want=0", cancel_button); end
    @(negedge clk); key_press = 1'b0;
    repeat (8) @(negedge clk);
    total++; if (n_cancel - c0 !== 1) begin bad++; $display("FAIL cancel_pulses got=%0d want=1", n_cancel - c0); end
  endtask

  task automatic test_door;
    int seen_high;
    seen_high = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      door_raw = (i % 4) < 2;
      seen_high += int'(door_status);
    end
    total++; if (seen_high !== 0) begin bad++; $display("FAIL door_toggle got=%0d want=0", seen_high); end
    @(negedge clk); door_raw = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++; if (door_status !== 1'b0) begin bad++; $display("FAIL door_early got=%b want=0", door_status); end
    @(posedge clk);
    #1;
    total++; if (door_status !== 1'b1) begin bad++; $display("FAIL door_edge6 got=%b want=1", door_status); end
  endtask

  task automatic test_reset_mid_press;
    press_key(4'd10);
    press_key(4'd8);
    total++; if ({power, door_status, timer} !== {1'b1, 1'b1, 7'd8}) begin
      bad++; $display("FAIL pre_reset got=%b/%b/%0d want=1/1/8", power, door_status, timer);
    end
    @(negedge clk); key_code = 4'd3; key_press = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (timer !== 7'd0) begin bad++; $display("FAIL async_timer got=%0d want=0", timer); end
    total++; if ({power, door_status, start_button, cancel_button, entry_error} !== 5'b0) begin
      bad++; $display("FAIL async_flags got=%b want=00000",
                      {power, door_status, start_button, cancel_button, entry_error});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++; if (timer !== 7'd0) begin bad++; $display("FAIL held_early got=%0d want=0", timer); end
    @(posedge clk);
    #1;
    total++; if (timer !== 7'd3) begin bad++; $display("FAIL held_new_press got=%0d want=3", timer); end
    @(negedge clk); key_press = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_entry_start();
    test_overflow();
    test_glitch_switch();
    test_power_cancel();
    test_door();
    test_reset_mid_press();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/panel_entry.md
Name: panel_entry

Overview:
- Front-panel input block that produces the microwave controller's command inputs.
- Turns raw keypad and door-switch levels into a validated timer value (0–120 s), a power level, single-cycle start/cancel pulses and a clean door level.
- Sits between the physical panel pins and the controller. It is the input end of the panel, where the controller is the display/output end.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples needed before a key or door level is accepted (legal range 1 to 255).
- MAX_TIME, 120: largest timer value accepted from digit entry.
- MAX_DIGITS, 3: maximum digits per entry sequence.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_press  in  1  raw keypad "a key is down" level; asynchronous to clk.
- key_code  in  4  raw code of the key that is down; valid while key_press=1.
- door_raw  in  1  raw door switch: 0 open, 1 closed.
- timer  out  7  entered heat time in seconds.
- power  out  1  0 HALF, 1 FULL.
- door_status  out  1  debounced door level: 0 open, 1 closed.
- start_button  out  1  one-cycle start pulse.
- cancel_button  out  1  one-cycle cancel pulse.
- entry_error  out  1  one-cycle pulse on a rejected digit.

Behaviour:
- Reset (rst_n=0, asynchronous): timer=0, power=0, door_status=0, start_button=0, cancel_button=0, entry_error=0, digit count=0, key FSM in RELEASED, all counters 0, synchronizers cleared.
- Synchronization: key_press, key_code and door_raw each pass through a 2-flop synchronizer before any other use.
- Key FSM states:
  - RELEASED: wait for sync key_press=1, then go to PRESS_DB.
  - PRESS_DB: count samples while key_press=1 and key_code equals the code captured on entry. A code change reloads the captured code and restarts the count. key_press=0 returns to RELEASED. When the count reaches DEBOUNCE_CYCLES, execute the action once and go to HELD.
  - HELD: no further action while the key is held; key_press=0 goes to RELEASE_DB.
  - RELEASE_DB: DEBOUNCE_CYCLES consecutive key_press=0 samples go to RELEASED; any 1 sample returns to HELD.
- Latency: with inputs held stable, the action's outputs are visible exactly DEBOUNCE_CYCLES+2 rising edges after the first edge sampling raw key_press=1. Exactly one action per physical press.
- Key actions (codes are package constants):
  - 0–9 DIGIT:
    - Compute nxt = timer*10 + d in 11-bit arithmetic.
    - If digit count < MAX_DIGITS and nxt <= MAX_TIME: timer=nxt[6:0] and digit count +1.
    - Otherwise timer and digit count are unchanged and entry_error=1 for one cycle.
  - 10 POWER: power toggles; timer unchanged.
  - 11 CLEAR: timer=0, digit count=0.
  - 12 START: start_button=1 for exactly one cycle; digit count=0 so the next digit begins a fresh entry; timer retained.
  - 13 CANCEL: cancel_button=1 for exactly one cycle; timer=0; digit count=0.
  - 14, 15: no effect, no error.
- Fresh entry after START: the first digit replaces timer (nxt = d) rather than appending.
- Door: an independent debouncer. door_status changes only after DEBOUNCE_CYCLES consecutive synchronized samples differing from its current value; any agreeing sample resets the count. door_status is independent of the key FSM.
- Pulses: start_button, cancel_button and entry_error are never high in two consecutive cycles and never high simultaneously.
- Reset mid-press: all state clears. A key still held when rst_n deasserts is treated as a new press, debounced from RELEASED.
- timer never exceeds MAX_TIME by construction.

Decomposition:
- Package panel_pkg: key code constants (KEY_POWER=10, KEY_CLEAR=11, KEY_START=12, KEY_CANCEL=13), key FSM state enum, MAX_TIME, MAX_DIGITS.
- One natural sub-module, level_debounce: parameterized width and DEBOUNCE_CYCLES, containing 2-flop sync, counter and stable output. Instantiate it for door_raw; the key FSM reuses its synchronizer only.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then press digit 9 cleanly -> timer=9 exactly 6 edges after the first high sample; start_button, cancel_button and entry_error stay 0.
- Keys 1,2,0 then START -> timer=12, then 120. start_button is high for one cycle and timer stays 120. Then digit 5 -> timer=5 (fresh entry).
- Keys 1,2,1 -> timer=12 after the second digit; the third digit pulses entry_error once and timer stays 12. A fourth digit after 1,0,0 pulses entry_error with timer=100.
- key_press glitching 1,1,0,1 before stable, and a code switching 3→7 mid-debounce -> exactly one action, digit 7, applied 4 stable samples after the switch.
- POWER twice, then CANCEL with timer=45 -> power 1 then 0. cancel_button pulses once and timer=0 on the same edge.
- door_raw toggling every 2 cycles, then held at 1 -> door_status stays 0 through the toggling and goes to 1 six edges after the hold begins. rst_n low mid-press clears every output asynchronously.
